// File: rtl/ram_dma_pkg.sv
// rtl/ram_dma_pkg.sv - shared state encoding and mode constants for the RAM DMA engine
package ram_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

  localparam int LEN_WIDTH = 9;

endpackage

// File: rtl/ram_dma.sv
// rtl/ram_dma.sv - word fill/copy DMA engine driving a single-port RAM with combinational read
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_value,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_store,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_result
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  state_t                state, state_n;
  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [LEN_WIDTH-1:0]  count_q;
  logic [DATA_WIDTH-1:0] fill_q, buf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_FILL;
      src_q   <= '0;
      dst_q   <= '0;
      count_q <= '0;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (start && length != '0) begin
            mode_q  <= mode;
            src_q   <= src_addr & WORD_MASK;
            dst_q   <= dst_addr & WORD_MASK;
            count_q <= length;
            fill_q  <= fill_value;
          end
        end
        ST_READ: buf_q <= mem_result;
        ST_WRITE: begin
          // Address arithmetic wraps naturally at the top of the RAM.
          count_q <= count_q - 1'b1;
          src_q   <= src_q + WORD_STEP;
          dst_q   <= dst_q + WORD_STEP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n     = state;
    busy        = 1'b0;
    done        = 1'b0;
    mem_store   = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (length == '0)        state_n = ST_DONE;
          else if (mode == MODE_COPY) state_n = ST_READ;
          else                     state_n = ST_WRITE;
        end
      end
      ST_READ: begin
        busy        = 1'b1;
        mem_address = src_q;
        state_n     = ST_WRITE;
      end
      ST_WRITE: begin
        busy        = 1'b1;
        // Gating with reset keeps an aborting edge from landing a stray write.
        mem_store   = !reset;
        mem_address = dst_q;
        mem_data    = (mode_q == MODE_COPY) ? buf_q : fill_q;
        if (count_q == LEN_WIDTH'(1)) state_n = ST_DONE;
        else if (mode_q == MODE_COPY) state_n = ST_READ;
        else                          state_n = ST_WRITE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_dma.sv
// tb/tb_ram_dma.sv - directed self-checking bench for ram_dma attached to a behavioural RAM
module tb_ram_dma;

  logic        clock;
  logic        reset;
  logic        start;
  logic        mode;
  logic [9:0]  src_addr;
  logic [9:0]  dst_addr;
  logic [8:0]  length;
  logic [31:0] fill_value;
  logic        busy;
  logic        done;
  logic        mem_store;
  logic [9:0]  mem_address;
  logic [31:0] mem_data;
  logic [31:0] mem_result;

  logic [31:0] ram [0:255];
  logic [7:0]  word_idx;
  logic        bd_we;
  logic [7:0]  bd_idx;
  logic [31:0] bd_val;

  int n_checks;
  int n_fail;

  ram_dma #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .busy(busy), .done(done),
    .mem_store(mem_store), .mem_address(mem_address),
    .mem_data(mem_data), .mem_result(mem_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign word_idx   = 8'(mem_address >> 2);
  assign mem_result = ram[word_idx];

  always @(posedge clock) begin
    if (bd_we) ram[bd_idx] <= bd_val;
    else if (mem_store) ram[word_idx] <= mem_data;
  end

  task automatic bd_write(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clock);
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    @(negedge clock);
    bd_we = 1'b0;
  endtask

  task automatic launch(input logic m, input logic [9:0] s, input logic [9:0] d,
                        input logic [8:0] len, input logic [31:0] fv);
    start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = len; fill_value = fv;
  endtask

  task automatic test_reset;
    @(negedge clock);
    reset = 1'b1;
    launch(1'b0, 10'h0, 10'h020, 9'd4, 32'h1234);
    repeat (2) @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (mem_store !== 1'b0) begin n_fail++; $display("FAIL reset_store got %b want 0", mem_store); end
    n_checks++; if (mem_address !== 10'h0) begin n_fail++; $display("FAIL reset_addr got %h want 000", mem_address); end
    n_checks++; if (mem_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", mem_data); end
    reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_prio_busy got %b want 0", busy); end
  endtask

  task automatic test_fill;
    logic [9:0] exp_addr;
    @(negedge clock);
    launch(1'b0, 10'h0, 10'h010, 9'd4, 32'hDEADBEEF);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 1) begin start = 1'b0; fill_value = 32'h0; dst_addr = 10'h3F0; length = 9'd0; end
      if (k <= 4) begin
        exp_addr = 10'(16 + 4 * (k - 1));
        n_checks++; if (mem_store !== 1'b1) begin n_fail++; $display("FAIL fill_store k=%0d got %b want 1", k, mem_store); end
        n_checks++; if (mem_address !== exp_addr) begin n_fail++; $display("FAIL fill_addr k=%0d got %h want %h", k, mem_address, exp_addr); end
        n_checks++; if (mem_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fill_data k=%0d got %h want deadbeef", k, mem_data); end
        n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL fill_busy k=%0d got busy=%b done=%b want 1/0", k, busy, done); end
      end else if (k == 5) begin
        n_checks++; if (done !== 1'b1 || busy !== 1'b0 || mem_store !== 1'b0) begin n_fail++; $display("FAIL fill_done got done=%b busy=%b store=%b want 1/0/0", done, busy, mem_store); end
      end else begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL fill_done_width got %b want 0", done); end
      end
    end
    for (int w = 4; w <= 7; w++) begin
      n_checks++; if (ram[w] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fill_ram[%0d] got %h want deadbeef", w, ram[w]); end
    end
  endtask

  task automatic test_copy;
    logic [9:0]  exp_addr;
    logic [31:0] exp_data;
    bd_write(8'd0, 32'd1);
    bd_write(8'd1, 32'd2);
    bd_write(8'd2, 32'd3);
    bd_write(8'd64, 32'h0);
    bd_write(8'd65, 32'h0);
    bd_write(8'd66, 32'h0);
    @(negedge clock);
    launch(1'b1, 10'h000, 10'h100, 9'd3, 32'hFFFF_FFFF);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (k == 1) begin start = 1'b0; src_addr = 10'h200; mode = 1'b0; end
      if (k <= 6 && (k % 2) == 1) begin
        exp_addr = 10'(4 * ((k - 1) / 2));
        n_checks++; if (mem_store !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL copy_read k=%0d got store=%b busy=%b want 0/1", k, mem_store, busy); end
        n_checks++; if (mem_address !== exp_addr) begin n_fail++; $display("FAIL copy_raddr k=%0d got %h want %h", k, mem_address, exp_addr); end
      end else if (k <= 6) begin
        exp_addr = 10'(256 + 4 * ((k - 2) / 2));
        exp_data = 32'((k - 2) / 2 + 1);
        n_checks++; if (mem_store !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL copy_write k=%0d got store=%b busy=%b want 1/1", k, mem_store, busy); end
        n_checks++; if (mem_address !== exp_addr) begin n_fail++; $display("FAIL copy_waddr k=%0d got %h want %h", k, mem_address, exp_addr); end
        n_checks++; if (mem_data !== exp_data) begin n_fail++; $display("FAIL copy_wdata k=%0d got %h want %h", k, mem_data, exp_data); end
      end else if (k == 7) begin
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL copy_done got done=%b busy=%b want 1/0", done, busy); end
      end else begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL copy_done_width got %b want 0", done); end
      end
    end
    for (int w = 0; w < 3; w++) begin
      n_checks++; if (ram[64 + w] !== 32'(w + 1)) begin n_fail++; $display("FAIL copy_ram[%0d] got %h want %0d", 64 + w, ram[64 + w], w + 1); end
    end
  endtask

  task automatic test_wrap;
    logic [9:0] exp_addr [0:2];
    exp_addr[0] = 10'h3F8; exp_addr[1] = 10'h3FC; exp_addr[2] = 10'h000;
    bd_write(8'd0, 32'h0);
    bd_write(8'd255, 32'h0);
    @(negedge clock);
    launch(1'b0, 10'h0, 10'h3F8, 9'd3, 32'h5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (k <= 3) begin
        n_checks++; if (mem_store !== 1'b1 || mem_address !== exp_addr[k-1]) begin n_fail++; $display("FAIL wrap_addr k=%0d got store=%b addr=%h want 1/%h", k, mem_store, mem_address, exp_addr[k-1]); end
      end else begin
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL wrap_done got %b want 1", done); end
      end
    end
    n_checks++; if (ram[0] !== 32'h5) begin n_fail++; $display("FAIL wrap_ram0 got %h want 5", ram[0]); end
    n_checks++; if (ram[255] !== 32'h5) begin n_fail++; $display("FAIL wrap_ram255 got %h want 5", ram[255]); end
  endtask

  task automatic test_zero_len;
    int n_store;
    n_store = 0;
    bd_write(8'd32, 32'h0);
    @(negedge clock);
    launch(1'b0, 10'h0, 10'h080, 9'd0, 32'h77);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == 1) start = 1'b0;
      if (mem_store === 1'b1) n_store++;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy k=%0d got %b want 0", k, busy); end
      n_checks++; if (done !== (k == 1)) begin n_fail++; $display("FAIL zero_done k=%0d got %b want %b", k, done, k == 1); end
    end
    n_checks++; if (n_store != 0) begin n_fail++; $display("FAIL zero_stores got %0d want 0", n_store); end
    n_checks++; if (ram[32] !== 32'h0) begin n_fail++; $display("FAIL zero_ram got %h want 0", ram[32]); end
  endtask

  task automatic test_reset_mid;
    int n_done;
    n_done = 0;
    bd_write(8'd1, 32'h0);
    bd_write(8'd2, 32'h0);
    bd_write(8'd3, 32'h0);
    @(negedge clock);
    launch(1'b0, 10'h0, 10'h004, 9'd8, 32'hA5A5A5A5);
    @(negedge clock);
    start = 1'b0;
    n_checks++; if (mem_store !== 1'b1 || mem_address !== 10'h004) begin n_fail++; $display("FAIL rmid_first got store=%b addr=%h want 1/004", mem_store, mem_address); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++; if (mem_store !== 1'b0) begin n_fail++; $display("FAIL rmid_store_gate got %b want 0", mem_store); end
    @(negedge clock);
    reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || mem_address !== 10'h0) begin n_fail++; $display("FAIL rmid_idle got busy=%b addr=%h want 0/000", busy, mem_address); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) n_done++;
    end
    n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL rmid_activity got %0d cycles want 0", n_done); end
    n_checks++; if (ram[1] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL rmid_ram1 got %h want a5a5a5a5", ram[1]); end
    n_checks++; if (ram[2] !== 32'h0 || ram[3] !== 32'h0) begin n_fail++; $display("FAIL rmid_ram23 got %h/%h want 0/0", ram[2], ram[3]); end
  endtask

  task automatic test_back_to_back;
    bd_write(8'd192, 32'h0);
    bd_write(8'd224, 32'h0);
    bd_write(8'd16, 32'h0);
    @(negedge clock);
    launch(1'b0, 10'h0, 10'h200, 9'd2, 32'h11);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      start = 1'b0;
      case (k)
        1: begin
          n_checks++; if (mem_store !== 1'b1 || mem_address !== 10'h200 || mem_data !== 32'h11) begin n_fail++; $display("FAIL b2b_w0 got store=%b addr=%h data=%h want 1/200/11", mem_store, mem_address, mem_data); end
          launch(1'b1, 10'h0, 10'h300, 9'd5, 32'h99);
        end
        2: begin
          n_checks++; if (mem_store !== 1'b1 || mem_address !== 10'h204 || mem_data !== 32'h11) begin n_fail++; $display("FAIL b2b_w1 got store=%b addr=%h data=%h want 1/204/11", mem_store, mem_address, mem_data); end
        end
        3: begin
          n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done got %b want 1", done); end
          launch(1'b0, 10'h0, 10'h380, 9'd1, 32'h33);
        end
        default: begin
          n_checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_store !== 1'b0) begin n_fail++; $display("FAIL b2b_ignored k=%0d got busy=%b done=%b store=%b want 0/0/0", k, busy, done, mem_store); end
        end
      endcase
    end
    launch(1'b0, 10'h0, 10'h040, 9'd1, 32'h22);
    @(negedge clock);
    start = 1'b0;
    n_checks++; if (mem_store !== 1'b1 || mem_address !== 10'h040 || mem_data !== 32'h22) begin n_fail++; $display("FAIL b2b_second got store=%b addr=%h data=%h want 1/040/22", mem_store, mem_address, mem_data); end
    @(negedge clock);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", done); end
    @(negedge clock);
    n_checks++; if (ram[16] !== 32'h22 || ram[128] !== 32'h11 || ram[129] !== 32'h11) begin n_fail++; $display("FAIL b2b_ram got %h/%h/%h want 22/11/11", ram[16], ram[128], ram[129]); end
    n_checks++; if (ram[192] !== 32'h0 || ram[224] !== 32'h0) begin n_fail++; $display("FAIL b2b_stray got %h/%h want 0/0", ram[192], ram[224]); end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    fill_value = '0;
    bd_we = 1'b0;
    bd_idx = '0;
    bd_val = '0;
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
